controle_pipe: RTL and testbench

- Next-generation main control unit for the RV32 reduced-ISA pipeline.
- Decodes the ID-stage opcode into the control bundle (ALUSrc, ALUOp, Branch, MemRead, MemWrite, Mem2Reg, RegWrite).
- Carries the bundle through EX, a parametrised number of MEM stages and WB.
- Detects load-use hazards (stall plus bubble) and applies branch/jump flushes, so the datapath needs no separate control pipeline registers.

---
 rtl/controle_pipe.sv | 192 +++++++++++++++++++
 tb/tb_controle_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_pipe.sv
// controle_pipe: RV32 main control, decode in ID, bundle carried to WB.
// Load-use stall and flush handling; optional ILLEGAL_TRAP_EN trap output.
module controle_pipe #(
  parameter int OPCODE_W = 7,
  parameter int REG_W    = 5,
  parameter int MEM_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rd,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                flush,
  output logic                stall,
  output logic                ex_alusrc,
  output logic [1:0]          ex_aluop,
  output logic [1:0]          ex_branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          wb_mem2reg,
  output logic                wb_regwrite,
`ifdef ILLEGAL_TRAP_EN
  output logic                ex_illegal,
  output logic [7:0]          illegal_cnt,
`endif
  output logic [REG_W-1:0]    wb_rd
);

  typedef struct packed {
    logic             valid;
    logic             is_load;
    logic [REG_W-1:0] rd;
    logic             alusrc;
    logic [1:0]       aluop;
    logic [1:0]       branch;
    logic             mread;
    logic             mwrite;
    logic [1:0]       m2r;
    logic             regwrite;
`ifdef ILLEGAL_TRAP_EN
    logic             illegal;
`endif
  } ctrl_t;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] OP_ST   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] OP_BR   = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] OP_I    = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] OP_JALR = OPCODE_W'(7'b1100111);
  localparam logic [OPCODE_W-1:0] OP_JAL  = OPCODE_W'(7'b1101111);

  function automatic ctrl_t bubble();
    ctrl_t b;
    b       = '0;
    b.aluop = 2'b11;
    return b;
  endfunction

  function automatic logic hz(
    input ctrl_t            s,
    input logic             u1,
    input logic             u2,
    input logic [REG_W-1:0] r1,
    input logic [REG_W-1:0] r2
  );
    return s.valid && s.is_load && (s.rd != '0)
      && ((u1 && s.rd == r1) || (u2 && s.rd == r2));
  endfunction

  ctrl_t dec, ex_d, ex_q, wb_q;
  ctrl_t mem_q [1:MEM_LAT];
  logic  use1, use2, ill, hit;
  logic  unused_ok;

  always_comb begin
    dec  = bubble();
    use1 = 1'b0;
    use2 = 1'b0;
    ill  = 1'b0;
    if (id_valid) begin
      unique case (1'b1)
        (id_opcode == OP_R): begin
          dec.regwrite = 1'b1;
          dec.aluop    = 2'b10;
          use1         = 1'b1;
          use2         = 1'b1;
        end
        (id_opcode == OP_LD): begin
          dec.alusrc   = 1'b1;
          dec.m2r      = 2'd1;
          dec.regwrite = 1'b1;
          dec.mread    = 1'b1;
          dec.is_load  = 1'b1;
          dec.aluop    = 2'b00;
          use1         = 1'b1;
        end
        (id_opcode == OP_ST): begin
          dec.alusrc = 1'b1;
          dec.mwrite = 1'b1;
          dec.aluop  = 2'b00;
          use1       = 1'b1;
          use2       = 1'b1;
        end
        (id_opcode == OP_BR): begin
          dec.branch = 2'd1;
          dec.aluop  = 2'b00;
          use1       = 1'b1;
          use2       = 1'b1;
        end
        (id_opcode == OP_I): begin
          dec.alusrc   = 1'b1;
          dec.regwrite = 1'b1;
          dec.aluop    = 2'b00;
          use1         = 1'b1;
        end
        (id_opcode == OP_JALR): begin
          dec.alusrc   = 1'b1;
          dec.m2r      = 2'd2;
          dec.regwrite = 1'b1;
          dec.branch   = 2'd3;
          dec.aluop    = 2'b00;
          use1         = 1'b1;
        end
        (id_opcode == OP_JAL): begin
          dec.m2r      = 2'd2;
          dec.regwrite = 1'b1;
          dec.branch   = 2'd2;
          dec.aluop    = 2'b00;
        end
        default: ill = 1'b1;
      endcase
      if (!ill) begin
        dec.valid = 1'b1;
        dec.rd    = id_rd;
      end
    end
`ifdef ILLEGAL_TRAP_EN
    dec.illegal = ill;
`endif
  end

  // the last MEM stage is forwarded, so it never stalls
  always_comb begin
    hit = hz(ex_q, use1, use2, id_rs1, id_rs2);
    for (int j = 1; j < MEM_LAT; j++)
      hit = hit | hz(mem_q[j], use1, use2, id_rs1, id_rs2);
  end

  assign stall = id_valid & ~flush & hit;
  assign ex_d  = (stall | flush) ? bubble() : dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= bubble();
      for (int j = 1; j <= MEM_LAT; j++)
        mem_q[j] <= bubble();
      wb_q <= bubble();
    end else begin
      ex_q     <= ex_d;
      mem_q[1] <= ex_q;
      for (int j = 2; j <= MEM_LAT; j++)
        mem_q[j] <= mem_q[j-1];
      wb_q <= mem_q[MEM_LAT];
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= 8'd0;
    else if (ex_d.illegal && illegal_cnt != 8'hff)
      illegal_cnt <= illegal_cnt + 8'd1;
  end

  assign ex_illegal = ex_q.illegal;
`endif

  assign ex_alusrc   = ex_q.alusrc;
  assign ex_aluop    = ex_q.aluop;
  assign ex_branch   = ex_q.branch;
  assign mem_read    = mem_q[MEM_LAT].mread;
  assign mem_write   = mem_q[MEM_LAT].mwrite;
  assign wb_mem2reg  = wb_q.m2r;
  assign wb_regwrite = wb_q.regwrite;
  assign wb_rd       = wb_q.rd;

  assign unused_ok = ^{wb_q, mem_q[MEM_LAT]};

endmodule

// File: tb/tb_controle_pipe.sv
// tb_controle_pipe: two DUTs (MEM_LAT 1 and 2) checked every cycle
// against a history-based model, plus directed literal checks.
module tb_controle_pipe;

  logic       clk = 1'b0;
  logic       rst_n, id_valid, flush;
  logic [6:0] id_opcode;
  logic [4:0] id_rd, id_rs1, id_rs2;

  logic       stall_o  [2];
  logic       alusrc_o [2];
  logic [1:0] aluop_o  [2];
  logic [1:0] br_o     [2];
  logic       mr_o     [2];
  logic       mw_o     [2];
  logic [1:0] m2r_o    [2];
  logic       rw_o     [2];
  logic [4:0] rd_o     [2];
`ifdef ILLEGAL_TRAP_EN
  logic       ill_o    [2];
  logic [7:0] cnt_o    [2];
`endif

  always #5 clk = ~clk;

  controle_pipe #(.MEM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .flush(flush),
    .stall(stall_o[0]), .ex_alusrc(alusrc_o[0]),
    .ex_aluop(aluop_o[0]), .ex_branch(br_o[0]),
    .mem_read(mr_o[0]), .mem_write(mw_o[0]),
    .wb_mem2reg(m2r_o[0]), .wb_regwrite(rw_o[0]),
`ifdef ILLEGAL_TRAP_EN
    .ex_illegal(ill_o[0]), .illegal_cnt(cnt_o[0]),
`endif
    .wb_rd(rd_o[0])
  );

  controle_pipe #(.MEM_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .flush(flush),
    .stall(stall_o[1]), .ex_alusrc(alusrc_o[1]),
    .ex_aluop(aluop_o[1]), .ex_branch(br_o[1]),
    .mem_read(mr_o[1]), .mem_write(mw_o[1]),
    .wb_mem2reg(m2r_o[1]), .wb_regwrite(rw_o[1]),
`ifdef ILLEGAL_TRAP_EN
    .ex_illegal(ill_o[1]), .illegal_cnt(cnt_o[1]),
`endif
    .wb_rd(rd_o[1])
  );

  typedef struct packed {
    logic       ld;
    logic [4:0] rd;
    logic       as;
    logic [1:0] op;
    logic [1:0] br;
    logic       mr;
    logic       mw;
    logic [1:0] m2r;
    logic       rw;
    logic       ill;
    logic       u1;
    logic       u2;
  } rec_t;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  // hist[l][k]: what entered EX k edges ago on lane l
  rec_t hist [2][8];
  logic xstall [2];
  int   icnt [2];
  int   checks = 0;
  int   errors = 0;

  function automatic rec_t dec(
    input logic v, input logic [6:0] op, input logic [4:0] rd
  );
    rec_t r;
    r    = '0;
    r.op = 2'b11;
    if (!v) return r;
    case (op)
      7'b0110011: begin r.rw = 1; r.op = 2; r.u1 = 1; r.u2 = 1; end
      7'b0000011: begin
        r.as = 1; r.m2r = 1; r.rw = 1; r.mr = 1;
        r.op = 0; r.u1 = 1; r.ld = 1;
      end
      7'b0100011: begin
        r.as = 1; r.mw = 1; r.op = 0; r.u1 = 1; r.u2 = 1;
      end
      7'b1100011: begin r.br = 1; r.op = 0; r.u1 = 1; r.u2 = 1; end
      7'b0010011: begin r.as = 1; r.rw = 1; r.op = 0; r.u1 = 1; end
      7'b1100111: begin
        r.as = 1; r.m2r = 2; r.rw = 1; r.br = 3; r.op = 0; r.u1 = 1;
      end
      7'b1101111: begin r.m2r = 2; r.rw = 1; r.br = 2; r.op = 0; end
      default: begin r.ill = 1; return r; end
    endcase
    r.rd = rd;
    return r;
  endfunction

  task automatic cmp(
    input string nm, input int l,
    input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d got %0h want %0h at %0t",
               nm, l, act, exp, $time);
    end
  endtask

  task automatic check_lane(input int l);
    int   ml = l + 1;
    rec_t c  = dec(id_valid, id_opcode, id_rd);
    logic hz = 1'b0;
    rec_t e, m, w;
    for (int k = 0; k < ml; k++) begin
      rec_t h = hist[l][k];
      if (h.ld && h.rd != 0 &&
          ((c.u1 && h.rd == id_rs1) || (c.u2 && h.rd == id_rs2)))
        hz = 1'b1;
    end
    xstall[l] = rst_n && id_valid && !flush && hz;
    e = hist[l][0];
    m = hist[l][ml];
    w = hist[l][ml+1];
    cmp("stall", l, stall_o[l], xstall[l]);
    cmp("ex_alusrc", l, alusrc_o[l], e.as);
    cmp("ex_aluop", l, aluop_o[l], e.op);
    cmp("ex_branch", l, br_o[l], e.br);
    cmp("mem_read", l, mr_o[l], m.mr);
    cmp("mem_write", l, mw_o[l], m.mw);
    cmp("wb_mem2reg", l, m2r_o[l], w.m2r);
    cmp("wb_regwrite", l, rw_o[l], w.rw);
    cmp("wb_rd", l, rd_o[l], w.rd);
`ifdef ILLEGAL_TRAP_EN
    cmp("ex_illegal", l, ill_o[l], e.ill);
    cmp("illegal_cnt", l, cnt_o[l], icnt[l]);
`endif
  endtask

  task automatic advance(input int l);
    rec_t c = dec(id_valid, id_opcode, id_rd);
    for (int k = 7; k > 0; k--) hist[l][k] = hist[l][k-1];
    if (!rst_n || xstall[l] || flush) hist[l][0] = dec(1'b0, 7'd0, 5'd0);
    else hist[l][0] = c;
    if (hist[l][0].ill && icnt[l] < 255) icnt[l]++;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_lane(0);
    check_lane(1);
    @(posedge clk);
    advance(0);
    advance(1);
    #1;
  endtask

  task automatic set_id(
    input logic v, input logic [6:0] op,
    input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2
  );
    id_valid  = v;
    id_opcode = op;
    id_rd     = rd;
    id_rs1    = r1;
    id_rs2    = r2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int l = 0; l < 2; l++) begin
      icnt[l] = 0;
      for (int k = 0; k < 8; k++) hist[l][k] = dec(1'b0, 7'd0, 5'd0);
    end
    #1;
    for (int l = 0; l < 2; l++) begin
      cmp("rst_aluop", l, aluop_o[l], 3);
      cmp("rst_stall", l, stall_o[l], 0);
      cmp("rst_regwrite", l, rw_o[l], 0);
      cmp("rst_memread", l, mr_o[l], 0);
      cmp("rst_rd", l, rd_o[l], 0);
    end
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  logic [6:0] ops [8];

  initial begin
    ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0010011, 7'b1100111, 7'b1101111, 7'b1111111};
    flush = 1'b0;
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    xstall[0] = 1'b0;
    xstall[1] = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    cycle();
    cycle();
    rst_n = 1'b1;

    // lw x5 then dependent add
    set_id(1'b1, LW, 5'd5, 5'd1, 5'd0);
    #1;
    cmp("lw_stall", 0, stall_o[0], 0);
    cycle();
    cmp("lw_ex_alusrc", 0, alusrc_o[0], 1);
    cmp("lw_ex_aluop", 0, aluop_o[0], 0);
    set_id(1'b1, ADD, 5'd6, 5'd5, 5'd1);
    #1;
    cmp("lu_stall1", 0, stall_o[0], 1);
    cmp("lu_stall1", 1, stall_o[1], 1);
    cycle();
    cmp("lw_mem_read", 0, mr_o[0], 1);
    cmp("lu_bubble", 0, aluop_o[0], 3);
    cmp("lu_stall2", 0, stall_o[0], 0);
    cmp("lu_stall2", 1, stall_o[1], 1);
    cycle();
    cmp("lw_wb_m2r", 0, m2r_o[0], 1);
    cmp("lw_wb_rw", 0, rw_o[0], 1);
    cmp("lw_wb_rd", 0, rd_o[0], 5);
    cmp("add_in_ex", 0, aluop_o[0], 2);
    cmp("lu_stall3", 1, stall_o[1], 0);
    cmp("lw_mem_read", 1, mr_o[1], 1);
    cycle();
    idle(4);

    // lw x0 never stalls; jal uses no sources
    set_id(1'b1, LW, 5'd0, 5'd1, 5'd0);
    cycle();
    set_id(1'b1, ADD, 5'd7, 5'd0, 5'd0);
    #1;
    cmp("x0_stall", 0, stall_o[0], 0);
    cmp("x0_stall", 1, stall_o[1], 0);
    cycle();
    set_id(1'b1, LW, 5'd5, 5'd1, 5'd0);
    cycle();
    set_id(1'b1, JAL, 5'd1, 5'd5, 5'd5);
    #1;
    cmp("jal_stall", 0, stall_o[0], 0);
    cmp("jal_stall", 1, stall_o[1], 0);
    cycle();
    idle(4);

    // flush overrides stall
    set_id(1'b1, LW, 5'd5, 5'd1, 5'd0);
    cycle();
    set_id(1'b1, ADD, 5'd6, 5'd5, 5'd1);
    flush = 1'b1;
    #1;
    cmp("flush_stall", 0, stall_o[0], 0);
    cmp("flush_stall", 1, stall_o[1], 0);
    cycle();
    flush = 1'b0;
    set_id(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
    #1;
    cmp("flush_bubble", 0, aluop_o[0], 3);
    cmp("flush_bubble", 1, aluop_o[1], 3);
    idle(5);

    // jumps and illegal opcode
    set_id(1'b1, JALR, 5'd1, 5'd2, 5'd0);
    cycle();
    cmp("jalr_branch", 0, br_o[0], 3);
    set_id(1'b1, JAL, 5'd2, 5'd0, 5'd0);
    cycle();
    cmp("jal_branch", 0, br_o[0], 2);
    set_id(1'b1, 7'b1111111, 5'd3, 5'd0, 5'd0);
    cycle();
    cmp("ill_bubble", 0, aluop_o[0], 3);
    cmp("ill_bubble", 1, aluop_o[1], 3);
    cmp("jalr_wb_m2r", 0, m2r_o[0], 2);
    cmp("jalr_wb_rd", 0, rd_o[0], 1);
`ifdef ILLEGAL_TRAP_EN
    cmp("ill_pulse", 0, ill_o[0], 1);
    cmp("ill_cnt", 0, cnt_o[0], 1);
`endif
    idle(4);

    // randomized traffic with occasional mid-stream reset
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        cycle();
        rst_n = 1'b1;
        xstall[0] = 1'b0;
        xstall[1] = 1'b0;
      end
      if (!(xstall[0] || xstall[1])) begin
        logic [6:0] op;
        op = ops[$urandom_range(0, 7)];
        if ($urandom_range(0, 15) == 0) op = 7'($urandom);
        set_id($urandom_range(0, 9) != 0, op,
               5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)));
      end
      flush = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
